// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the shared memory.
// "master" is the CPU/memory side that drives requests and read data; "slave" is the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch I / load-store D) to one-port memory arbiter with Req/Ack handshakes.
// Define ARB_RR_EN for round-robin on conflicts; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_arbiter_if.slave     bus
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              owner_d_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic              busy_q;

    logic              any_req_s;
    logic              grant_d_s;
    logic              grant_we_s;

    assign any_req_s  = bus.i_req | bus.d_req;
    assign grant_we_s = grant_d_s & bus.d_we;

`ifdef ARB_RR_EN
    logic last_d_q;

    // On a conflict the port that did not win last time is granted.
    always_comb begin
        grant_d_s = bus.d_req;
        if (bus.d_req && bus.i_req) begin
            grant_d_s = ~last_d_q;
        end else begin
            grant_d_s = bus.d_req;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_d_q <= 1'b0;
        end else if (state_q == IDLE && any_req_s) begin
            last_d_q <= grant_d_s;
        end
    end
`else
    assign grant_d_s = bus.d_req;
`endif

    // Single FSM; every output is a register so nothing reaches the ports from Req combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            owner_d_q   <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            i_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_s) begin
                        state_q    <= ACCESS;
                        cnt_q      <= CNT_LOAD;
                        owner_d_q  <= grant_d_s;
                        we_q       <= grant_we_s;
                        mem_addr_q <= grant_d_s ? bus.d_addr : bus.i_addr;
                        if (grant_d_s) begin
                            mem_wdata_q <= bus.d_wdata;
                        end
                        mem_re_q   <= ~grant_we_s;
                        mem_we_q   <= grant_we_s;
                        busy_q     <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_q  <= DONE;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        i_ack_q  <= ~owner_d_q;
                        d_ack_q  <= owner_d_q;
                        // Writes leave D_RData holding the last load.
                        if (!owner_d_q) begin
                            i_rdata_q <= bus.mem_rdata;
                        end else if (!we_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    i_ack_q  <= 1'b0;
                    d_ack_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy_q;
endmodule
